// File: rtl/spart_receive_if.sv
// SPART receive-side bus: serial line, baud tick and the byte read port.
// The overrun flag is present only when SPART_RX_OVERRUN_EN is defined.
interface spart_receive_if;
    logic       rxd;
    logic       receive_baud;
    logic       receive_read_en;
    logic [7:0] receive_read_line;
    logic       rda;
    logic       framing_err;
`ifdef SPART_RX_OVERRUN_EN
    logic       overrun;

    modport master (
        output rxd, receive_baud, receive_read_en,
        input  receive_read_line, rda, framing_err, overrun
    );
    modport slave (
        input  rxd, receive_baud, receive_read_en,
        output receive_read_line, rda, framing_err, overrun
    );
`else
    modport master (
        output rxd, receive_baud, receive_read_en,
        input  receive_read_line, rda, framing_err
    );
    modport slave (
        input  rxd, receive_baud, receive_read_en,
        output receive_read_line, rda, framing_err
    );
`endif
endinterface

// File: rtl/spart_receive.sv
// SPART 8N1 receiver: oversampled start/data/stop recovery into a one-byte holding register.
// Optional sticky overrun flag enabled by defining SPART_RX_OVERRUN_EN.
module spart_receive #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    spart_receive_if.slave rx_if
);
    localparam int unsigned   TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_q;
    logic                   w_rxs;

    logic [1:0]    r_state, w_state;
    logic [TW-1:0] r_tick,  w_tick;
    logic [3:0]    r_bit,   w_bit;
    logic [7:0]    r_shift, w_shift;
    logic          w_load;

    logic [7:0] r_line;
    logic       r_rda;
    logic       r_ferr;

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // Synchronizer presets high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_rxd_q <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_if.rxd};
            r_rxd_q <= w_rxs;
        end
    end

    always_comb begin
        w_state = r_state;
        w_tick  = r_tick;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_load  = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_rxd_q && !w_rxs) begin
                    w_state = StStart;
                    w_tick  = '0;
                end
            end
            StStart: begin
                if (rx_if.receive_baud) begin
                    if (r_tick == HALF_LAST) begin
                        w_tick  = '0;
                        w_bit   = '0;
                        w_state = w_rxs ? StIdle : StData;
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            StData: begin
                // tick_cnt wraps to zero at each sample point (power-of-two oversample)
                if (rx_if.receive_baud) begin
                    w_tick = r_tick + 1'b1;
                    if (r_tick == FULL_LAST) begin
                        w_shift = {w_rxs, r_shift[7:1]};
                        w_bit   = r_bit + 4'd1;
                        if (r_bit == 4'd7) w_state = StStop;
                    end
                end
            end
            StStop: begin
                if (rx_if.receive_baud) begin
                    w_tick = r_tick + 1'b1;
                    if (r_tick == FULL_LAST) begin
                        w_load  = 1'b1;
                        w_state = StIdle;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_shift <= w_shift;
        end
    end

`ifdef SPART_RX_OVERRUN_EN
    logic r_ovr;
`endif

    // A load takes priority over a read issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= 8'h00;
            r_rda  <= 1'b0;
            r_ferr <= 1'b0;
`ifdef SPART_RX_OVERRUN_EN
            r_ovr  <= 1'b0;
`endif
        end else if (w_load) begin
            r_line <= r_shift;
            r_rda  <= 1'b1;
            r_ferr <= ~w_rxs;
`ifdef SPART_RX_OVERRUN_EN
            r_ovr  <= rx_if.receive_read_en ? 1'b0 : (r_ovr | r_rda);
`endif
        end else if (rx_if.receive_read_en && r_rda) begin
            r_rda  <= 1'b0;
            r_ferr <= 1'b0;
`ifdef SPART_RX_OVERRUN_EN
            r_ovr  <= 1'b0;
`endif
        end
    end

    assign rx_if.receive_read_line = r_line;
    assign rx_if.rda               = r_rda;
    assign rx_if.framing_err       = r_ferr;
`ifdef SPART_RX_OVERRUN_EN
    assign rx_if.overrun           = r_ovr;
`endif

endmodule

// File: tb/tb_spart_receive.sv
// Randomized self-checking bench for spart_receive against a frame-level reference model.
module tb_spart_receive;
    localparam int unsigned OS       = 16;
    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned BIT_CLKS = OS * BAUD_DIV;
    localparam int unsigned STOP_TICK = OS / 2 + 9 * OS;

    logic clk = 1'b0;
    logic rst;

    spart_receive_if u_if ();

    spart_receive #(
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .rx_if(u_if)
    );

    always #5 clk = ~clk;

    initial begin
        u_if.receive_baud = 1'b0;
        forever begin
            for (int k = 0; k < int'(BAUD_DIV); k++) begin
                @(negedge clk);
                u_if.receive_baud = (k == int'(BAUD_DIV) - 1);
            end
        end
    end

    // Reference model: holding register state after each complete frame / read
    logic [7:0] m_line;
    logic       m_rda;
    logic       m_ferr;
    logic       m_ovr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".line"}, u_if.receive_read_line, m_line);
        check_eq({tag, ".rda"},  {7'd0, u_if.rda},         {7'd0, m_rda});
        check_eq({tag, ".ferr"}, {7'd0, u_if.framing_err}, {7'd0, m_ferr});
`ifdef SPART_RX_OVERRUN_EN
        check_eq({tag, ".ovr"},  {7'd0, u_if.overrun},     {7'd0, m_ovr});
`endif
    endtask

    task automatic send_bit(input logic b);
        u_if.rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic model_load(input logic [7:0] d, input logic stop);
        m_ovr  = m_ovr | m_rda;
        m_line = d;
        m_rda  = 1'b1;
        m_ferr = ~stop;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input string tag);
        send_frame(d, stop);
        model_load(d, stop);
        check_all(tag);
    endtask

    task automatic do_read(input string tag);
        u_if.receive_read_en = 1'b1;
        @(negedge clk);
        u_if.receive_read_en = 1'b0;
        if (m_rda) begin
            m_rda  = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        check_all(tag);
    endtask

    // Raise read_en in the cycle of the stop-sampling tick, counted from start detection
    task automatic read_at_load();
        int n;
        repeat (3) @(posedge clk);
        n = 0;
        while (n < int'(STOP_TICK) - 1) begin
            @(posedge clk);
            if (u_if.receive_baud) n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!u_if.receive_baud && n < 2 * int'(BAUD_DIV));
        u_if.receive_read_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.receive_read_en = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        int         gap;

        rst                  = 1'b1;
        u_if.rxd             = 1'b1;
        u_if.receive_read_en = 1'b0;
        m_line = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        repeat (2) send_bit(1'b1);

        rx_frame(8'hA5, 1'b1, "nominal");
        do_read("nominal_rd");

        u_if.rxd = 1'b0;
        repeat (4 * BAUD_DIV) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_all("false_start");
        rx_frame(8'h3C, 1'b1, "after_false");
        do_read("after_false_rd");

        rx_frame(8'h81, 1'b0, "framing");
        send_bit(1'b1);
        do_read("framing_rd");

        rx_frame(8'h11, 1'b1, "ovr_first");
        rx_frame(8'h22, 1'b1, "ovr_second");
        do_read("ovr_rd");

        rx_frame(8'h66, 1'b1, "pend");
        fork
            send_frame(8'h77, 1'b1);
            read_at_load();
        join
        m_line = 8'h77;
        m_rda  = 1'b1;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("coincide");
        do_read("coincide_rd");

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        u_if.rxd = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        m_line = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("midframe_rst");
        rst = 1'b0;
        send_bit(1'b1);
        rx_frame(8'h5A, 1'b1, "after_rst");
        do_read("after_rst_rd");

        for (int it = 0; it < 20; it++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rx_frame(d, stop, "rand");
            gap = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) send_bit(1'b1);
            if ($urandom_range(0, 1) == 1) do_read("rand_rd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spart_receive.md
# spart_receive

Receive half of the SPART serial port. Recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the asynchronous `rxd` line. It oversamples `rxd` with a 16x baud tick from the shared baud generator and holds each received byte in a one-entry buffer until the bus side reads it. It is the counterpart to the SPART transmit block and sits beside it under the SPART top level.

## Interface
Parameters:
- `OVERSAMPLE`, 16: baud ticks per bit period; must be a power of two, ≥ 8.
- `SYNC_STAGES`, 2: flops in the `rxd` synchronizer (≥ 2).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rxd`  in  1  serial input; asynchronous to `clk`; idles high.
- `receive_baud`  in  1  one-`clk` pulse at `OVERSAMPLE`× the bit rate.
- `receive_read_en`  in  1  read strobe; consumes the buffered byte.
- `receive_read_line`  out  8  holding register (last received byte).
- `rda`  out  1  received data available.
- `framing_err`  out  1  the byte in `receive_read_line` had stop bit = 0.
- `overrun`  out  1  exists only with `SPART_RX_OVERRUN_EN`; see Configuration.

## Operation
- `rxd` passes through `SYNC_STAGES` flops, preset to 1 on reset. One further flop (`rxd_q`) is used for edge detection. All logic below uses the synchronized value `rxs`.
- The FSM has four states: IDLE, START, DATA and STOP. It uses `tick_cnt` (log2 `OVERSAMPLE` bits) and `bit_cnt` (4 bits). `tick_cnt` advances only on cycles where `receive_baud` = 1.
- **IDLE**: a falling edge (`rxd_q`=1, `rxs`=0) moves to START and clears `tick_cnt`.
- **START**: when `tick_cnt` reaches `OVERSAMPLE/2 - 1` on a tick, sample `rxs`.
  - If the sample is 0: go to DATA, clear `tick_cnt` and `bit_cnt`.
  - If the sample is 1 (false start): go back to IDLE with no output change.
- **DATA**: on every tick with `tick_cnt` = `OVERSAMPLE - 1`, sample `rxs` into the shift register as `{rxs, shift[7:1]}` (LSB first) and increment `bit_cnt`. After the 8th sample, go to STOP.
- **STOP**: at the next mid-bit point, sample the stop bit.
  - Load the shift register into `receive_read_line`.
  - Set `rda` = 1.
  - Set `framing_err` = ~stop sample.
  - Return to IDLE. Returning at mid-stop lets the next start edge be detected immediately.
- **Read**: `receive_read_en` while `rda` = 1 clears `rda`, `framing_err` and `overrun` on the next edge. `receive_read_line` keeps its value. A read while `rda` = 0 has no effect.
- **Load and read in the same cycle**: the load wins. `rda` stays 1, the new byte and new `framing_err` are visible, and `overrun` is not set.
- **Load while `rda` = 1 with no read**: the new byte overwrites the holding register.
- **Reset mid-frame**: FSM goes to IDLE, counters clear, the synchronizer presets to 1 and the partial byte is discarded.

## Timing
- Reset values:
  - `receive_read_line` = 8'h00
  - `rda` = 0
  - `framing_err` = 0
  - `overrun` = 0
  - FSM = IDLE
- Edge detect latency: `SYNC_STAGES` + 1 `clk` after `rxd` falls.
- `rda`, `receive_read_line` and `framing_err` update on the `clk` edge after the stop-bit sampling tick; all are registered outputs.
- Data bit n (0..7) is sampled at `OVERSAMPLE/2 + (n+1)·OVERSAMPLE` ticks after start detection. This is within ±1 tick of bit center, plus the synchronizer delay.
- Back-to-back frames with no idle gap are received without loss.
- `receive_baud` pulses must be at least 2 `clk` apart.

## Configuration
- `SPART_RX_OVERRUN_EN` defined:
  - The `overrun` port exists.
  - It is set when a byte loads while `rda` = 1 and `receive_read_en` = 0.
  - It is sticky until a read and cleared on reset.
- Not defined:
  - The port and its logic are absent.
  - Overwrite behaviour is unchanged and silent.

## Test plan
- **Nominal frame**: `receive_baud` every 4 `clk`; send 0xA5 with stop = 1. Expect `rda` = 1, `receive_read_line` = 0xA5, `framing_err` = 0. Then pulse `receive_read_en`: `rda` = 0 next cycle and the line still reads 0xA5.
- **False start**: drive `rxd` low for 4 ticks only. Expect `rda` to stay 0. Then send 0x3C normally and expect it received intact.
- **Framing error**: send 0x81 with stop = 0. Expect `rda` = 1, `receive_read_line` = 0x81, `framing_err` = 1. After a read, `framing_err` = 0.
- **Overrun (macro on)**: send 0x11 then 0x22 back-to-back with no read. Expect `receive_read_line` = 0x22 and `overrun` = 1; a read clears it. With the macro off, only 0x22 is observed and no flag exists.
- **Read coinciding with load**: assert `receive_read_en` in the same cycle that 0x77 loads while 0x66 is pending. Expect `rda` = 1, the line reads 0x77, and `overrun` = 0.
- **Reset mid-frame**: assert `rst` after data bit 3 of a frame. Expect all outputs at reset values. Then send 0x5A and expect exactly 0x5A with `framing_err` = 0.
